// File: rtl/alu_ex_stage_pkg.sv
// Operation codes and width defaults shared by the ALU control decoder and the execute stage.
// Codes 17-31 are unassigned and produce a zero result.
package alu_ex_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RA_W_DEF   = 5;

  typedef enum logic [4:0] {
    ALU_SLL  = 5'd0,
    ALU_SRL  = 5'd1,
    ALU_SRA  = 5'd2,
    ALU_SLLV = 5'd3,
    ALU_SRLV = 5'd4,
    ALU_SRAV = 5'd5,
    ALU_ADD  = 5'd6,
    ALU_ADDU = 5'd7,
    ALU_SUB  = 5'd8,
    ALU_SUBU = 5'd9,
    ALU_AND  = 5'd10,
    ALU_OR   = 5'd11,
    ALU_XOR  = 5'd12,
    ALU_NOR  = 5'd13,
    ALU_SLT  = 5'd14,
    ALU_SLTU = 5'd15,
    ALU_LUI  = 5'd16
  } alu_op_e;

endpackage

// File: rtl/alu_ex_stage_alu_core.sv
// Combinational ALU: shifter, adder/subtractor, logic ops, compares, signed-overflow detect.
// Latency: zero (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
module alu_core
  import alu_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [4:0]        alu_ctrl,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [4:0]        sh_var;
  logic              add_ovf;
  logic              sub_ovf;

  assign sum    = a + b;
  assign diff   = a - b;
  assign sh_var = a[4:0];

  // Same-sign operands whose sum flips sign; opposite-sign operands whose difference flips a's sign.
  assign add_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
  assign sub_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (alu_ctrl)
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SRA:  result = $unsigned($signed(b) >>> shamt);
      ALU_SLLV: result = b << sh_var;
      ALU_SRLV: result = b >> sh_var;
      ALU_SRAV: result = $unsigned($signed(b) >>> sh_var);
      ALU_ADD: begin
        result = sum;
        ovf    = add_ovf;
      end
      ALU_ADDU: result = sum;
      ALU_SUB: begin
        result = diff;
        ovf    = sub_ovf;
      end
      ALU_SUBU: result = diff;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_LUI:  result = {b[DATA_W-17:0], 16'h0000};
      default: begin
        result = '0;
        ovf    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_ex_stage.sv
// Execute stage: ALU result held in a one-entry output register toward memory/writeback.
// Latency: 1 cycle from accepted input to out_valid; 1 op/cycle with out_ready held high.
// Backpressure: in_ready = !out_valid | out_ready; the held entry is stable while out_ready is low.
module alu_ex_stage
  import alu_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RA_W   = RA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        alu_ctrl,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [RA_W-1:0]   rd_in,
  input  logic              we_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [RA_W-1:0]   rd_out,
  output logic              we_out,
  output logic              ovf_exc
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e            state;
  logic [DATA_W-1:0] core_result;
  logic              core_ovf;
  logic              capture;

  alu_core #(.DATA_W(DATA_W)) u_alu_core (
    .alu_ctrl (alu_ctrl),
    .shamt    (shamt),
    .a        (src_a),
    .b        (src_b),
    .result   (core_result),
    .ovf      (core_ovf)
  );

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  // A redirect kills both the held entry and anything handshaking in the same cycle.
  assign capture   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      result  <= '0;
      rd_out  <= '0;
      we_out  <= 1'b0;
      ovf_exc <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (capture) state <= FULL;
        FULL: begin
          if (flush)                       state <= EMPTY;
          else if (out_ready && !capture)  state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
      if (capture) begin
        result  <= core_result;
        rd_out  <= rd_in;
        we_out  <= we_in && !core_ovf;
        ovf_exc <= core_ovf;
      end
    end
  end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Scoreboard bench: arithmetic reference model pushes expected entries, a negedge monitor pops on drain.
// Directed cases cover overflow, shifts, compares, backpressure, flush and async reset; random traffic follows.
module tb_alu_ex_stage;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  alu_ctrl = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [4:0]  rd_in = '0;
  logic        we_in = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        we_out;
  logic        ovf_exc;

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_drain = 0;
  bit   model_full = 1'b0;
  exp_t exp_q[$];

  alu_ex_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .shamt     (shamt),
    .src_a     (src_a),
    .src_b     (src_b),
    .rd_in     (rd_in),
    .we_in     (we_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .rd_out    (rd_out),
    .we_out    (we_out),
    .ovf_exc   (ovf_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the instruction semantics.
  function automatic exp_t ref_op(input logic [4:0] op, input logic [4:0] sh_i,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] rd, input logic we);
    exp_t e;
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s;
    longint q;
    longint unsigned p;
    int sh;
    e.res = 32'd0;
    e.ovf = 1'b0;
    sh = (op >= 5'd3 && op <= 5'd5) ? int'(a % 32) : int'(sh_i);
    p = 64'd1 << sh;
    case (op)
      5'd0, 5'd3: e.res = 32'(ub * p);
      5'd1, 5'd4: e.res = 32'(ub / p);
      5'd2, 5'd5: begin
        q = sb / longint'(p);
        if (sb < 0 && q * longint'(p) != sb) q = q - 1;
        e.res = 32'(q);
      end
      5'd6: begin
        s = sa + sb;
        e.res = 32'(s);
        e.ovf = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
      end
      5'd7: e.res = 32'(ua + ub);
      5'd8: begin
        s = sa - sb;
        e.res = 32'(s);
        e.ovf = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
      end
      5'd9:  e.res = 32'(ua - ub);
      5'd10: e.res = a & b;
      5'd11: e.res = a | b;
      5'd12: e.res = a ^ b;
      5'd13: e.res = ~(a | b);
      5'd14: e.res = (sa < sb) ? 32'd1 : 32'd0;
      5'd15: e.res = (ua < ub) ? 32'd1 : 32'd0;
      5'd16: e.res = 32'(ub * 64'd65536);
      default: e.res = 32'd0;
    endcase
    e.rd = rd;
    e.we = we && !e.ovf;
    return e;
  endfunction

  // Model of the handshake: predicts in_ready/out_valid and pushes expected entries on acceptance.
  always @(negedge clk) begin
    bit exp_rdy;
    bit acc;
    if (!rst_n) begin
      model_full = 1'b0;
      exp_q.delete();
    end else begin
      exp_rdy = !model_full || out_ready;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("out_valid", {31'd0, out_valid}, {31'd0, model_full});
      acc = in_valid && exp_rdy && !flush;
      if (flush && model_full && !out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(ref_op(alu_ctrl, shamt, src_a, src_b, rd_in, we_in));
      model_full = flush ? 1'b0 : (acc ? 1'b1 : (out_ready ? 1'b0 : model_full));
    end
  end

  // Monitor: every drained entry is compared against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      n_drain++;
      if (exp_q.size() == 0) begin
        chk("drain_unexpected", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", result, e.res);
        chk("sb_rd", {27'd0, rd_out}, {27'd0, e.rd});
        chk("sb_we", {31'd0, we_out}, {31'd0, e.we});
        chk("sb_ovf", {31'd0, ovf_exc}, {31'd0, e.ovf});
      end
    end
  end

  task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic we, input logic fl, input logic ordy);
    in_valid = v; alu_ctrl = op; shamt = sh; src_a = a; src_b = b;
    rd_in = rd; we_in = we; flush = fl; out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'd0;
      4: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
    chk("rst_we_out", {31'd0, we_out}, 32'd0);
    chk("rst_ovf_exc", {31'd0, ovf_exc}, 32'd0);
    #10 rst_n = 1'b1;
    step();

    // add overflow held, then addu with the same operands
    drive(1, 5'd6, 5'd0, 32'h7FFFFFFF, 32'h00000001, 5'd3, 1, 0, 0);
    step();
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_result", result, 32'h80000000);
    chk("add_ovf", {31'd0, ovf_exc}, 32'd1);
    chk("add_we", {31'd0, we_out}, 32'd0);
    chk("add_rd", {27'd0, rd_out}, 32'd3);
    drive(1, 5'd7, 5'd0, 32'h7FFFFFFF, 32'h00000001, 5'd3, 1, 0, 1);
    step();
    chk("addu_ovf", {31'd0, ovf_exc}, 32'd0);
    chk("addu_we", {31'd0, we_out}, 32'd1);
    drive(1, 5'd2, 5'd4, 32'd0, 32'h80000010, 5'd4, 1, 0, 1);
    step();
    chk("sra_result", result, 32'hF8000001);
    drive(1, 5'd4, 5'd0, 32'h00000024, 32'h80000010, 5'd5, 1, 0, 1);
    step();
    chk("srlv_result", result, 32'h08000001);
    drive(1, 5'd14, 5'd0, 32'hFFFFFFFF, 32'd1, 5'd6, 1, 0, 1);
    step();
    chk("slt_result", result, 32'd1);
    drive(1, 5'd15, 5'd0, 32'hFFFFFFFF, 32'd1, 5'd6, 1, 0, 1);
    step();
    chk("sltu_result", result, 32'd0);
    drive(1, 5'd16, 5'd0, 32'd0, 32'h00001234, 5'd7, 1, 0, 1);
    step();
    chk("lui_result", result, 32'h12340000);
    drive(0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 0, 0, 1);
    step();

    // backpressure: held entry stable, then replaced in one edge
    drive(1, 5'd10, 5'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd8, 1, 0, 0);
    step();
    drive(1, 5'd11, 5'd0, 32'd1, 32'd2, 5'd9, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      chk("bp_hold_result", result, 32'h00F000F0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_no_bubble_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_new_result", result, 32'h00000003);
    drive(0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 0, 0, 1);
    step();

    // flush beats a simultaneous capture
    drive(1, 5'd12, 5'd0, 32'h000000FF, 32'h0000000F, 5'd10, 1, 0, 0);
    step();
    drive(1, 5'd8, 5'd0, 32'd10, 32'd3, 5'd11, 1, 1, 0);
    step();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_not_captured", result, 32'h000000F0);
    drive(0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0);
    step();
    chk("flush_stays_empty", {31'd0, out_valid}, 32'd0);

    // asynchronous reset while FULL
    drive(1, 5'd13, 5'd0, 32'd0, 32'd0, 5'd12, 1, 0, 0);
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_rd", {27'd0, rd_out}, 32'd0);
    chk("arst_we", {31'd0, we_out}, 32'd0);
    chk("arst_ovf", {31'd0, ovf_exc}, 32'd0);
    #3 rst_n = 1'b1;
    step();

    // ten back-to-back ops
    n0 = n_drain;
    for (int i = 0; i < 10; i++) begin
      drive(1, 5'($urandom_range(0, 16)), 5'($urandom), rnd_operand(), rnd_operand(),
            5'(i), 1, 0, 1);
      step();
      chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    end
    drive(0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 0, 0, 1);
    step();
    chk("b2b_count", n_drain - n0, 32'd10);

    // random traffic including unassigned codes
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom), 5'($urandom), rnd_operand(),
            rnd_operand(), 5'($urandom), 1'($urandom), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 2) != 0));
      step();
    end
    drive(0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 0, 0, 1);
    repeat (3) step();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ex_stage.md
# alu_ex_stage

Registered execute stage directly downstream of the ALU control decoder. Consumes the 5-bit ALU operation code and 5-bit shift amount that decoder produces, plus the two register/immediate operands and destination register number, and computes the result. The result is held in a one-entry output register with a valid/ready handshake toward the memory/writeback stage. Signed add/sub overflow is flagged as an exception and suppresses the register write.

## Interface
- `DATA_W`, 32, operand/result width; only 32 is supported (lui and shift widths depend on it)
- `RA_W`, 5, destination register address width
- `clk` input 1 — clock, all state on rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `in_valid` input 1 — upstream presents an operation
- `in_ready` output 1 — stage can accept this cycle
- `alu_ctrl` input 5 — operation code from ALU control
- `shamt` input 5 — immediate shift amount from ALU control (zero for non-immediate shifts)
- `src_a` input DATA_W — rs operand
- `src_b` input DATA_W — rt operand or extended immediate
- `rd_in` input RA_W — destination register
- `we_in` input 1 — instruction writes a register
- `flush` input 1 — kill the held result (branch/exception redirect)
- `out_valid` output 1 — result register holds a valid entry
- `out_ready` input 1 — downstream accepts the entry
- `result` output DATA_W — computed value
- `rd_out` output RA_W — destination register
- `we_out` output 1 — register write enable (0 on overflow)
- `ovf_exc` output 1 — signed overflow on add/sub

## Operation
- Operation codes (a = src_a, b = src_b):
  - 0 sll: b << shamt
  - 1 srl: b >> shamt
  - 2 sra: b >>> shamt
  - 3 sllv: b << a[4:0]
  - 4 srlv: b >> a[4:0]
  - 5 srav: b >>> a[4:0]
  - 6 add: a+b, trap on signed overflow
  - 7 addu: a+b, no trap
  - 8 sub: a−b, trap
  - 9 subu: a−b, no trap
  - 10 and, 11 or, 12 xor, 13 nor
  - 14 slt: signed a<b → 1 else 0
  - 15 sltu: unsigned
  - 16 lui: b << 16
- Codes 17–31: result 0, `ovf_exc` 0, `we_out` = `we_in`.
- Overflow rules:
  - add overflows when a and b have the same sign and the sum's sign differs.
  - sub overflows when a and b have different signs and the sign of a−b differs from a.
  - On overflow, the entry is still registered with `ovf_exc`=1 and `we_out`=0. The result field holds the wrapped sum.
- Handshake:
  - `in_ready` = !`out_valid` | `out_ready` (combinational, independent of `flush`).
  - Capture happens when `in_valid` & `in_ready` & !`flush`.
  - An entry leaves the register when `out_valid` & `out_ready`.
- Output register states are EMPTY (`out_valid`=0) and FULL (`out_valid`=1):
  - EMPTY→FULL on capture.
  - FULL→FULL on simultaneous drain and capture (new data replaces old in the same edge).
  - FULL→EMPTY on drain without capture.
  - FULL holds with data stable while `out_ready`=0.
- Flush: `out_valid` clears at the next edge. Any same-cycle input is dropped, even if the handshake fired; flush wins over capture.
- Data outputs (`result`, `rd_out`, `we_out`, `ovf_exc`) change only on capture. `we_out` and `ovf_exc` are meaningful only while `out_valid`=1.

## Timing
- Latency: 1 cycle from accepted input to `out_valid`. Throughput is 1 op/cycle when `out_ready` is held high.
- Reset values: `out_valid`=0, `result`=0, `rd_out`=0, `we_out`=0, `ovf_exc`=0.
- Reset asserted mid-operation discards the held entry immediately and asynchronously. The first capture after `rst_n` rises takes effect on the first rising edge at which a handshake is seen.
- Datapath from operand inputs to result register is single-cycle combinational: barrel shifter, adder/subtractor, comparators.
- No path from `out_ready` to data outputs. The only combinational output is `in_ready`.

## Structure
- Shared package holds:
  - the 5-bit ALU operation code constants (shared with ALU control)
  - the `DATA_W` and `RA_W` defaults
- One sub-module: `alu_core`, purely combinational. Inputs `alu_ctrl`, `shamt`, a, b; outputs result and overflow.
- `alu_ex_stage` wraps `alu_core` with the handshake, flush logic and output register.

## Test plan
- add 0x7FFFFFFF + 0x00000001, `we_in`=1, rd=3 → next cycle `out_valid`=1, `result`=0x80000000, `ovf_exc`=1, `we_out`=0; addu with the same operands → `ovf_exc`=0, `we_out`=1.
- sra with b=0x80000010, shamt=4 → `result`=0xF8000001; srlv with a=0x24 (uses 4), b=0x80000010 → `result`=0x08000001.
- slt with a=0xFFFFFFFF, b=1 → `result`=1; sltu with the same operands → 0; lui with b=0x00001234 → 0x12340000.
- Back-pressure: hold `out_ready`=0 with an entry held and issue a new op → `in_ready`=0, entry stable over 5 cycles; raise `out_ready` with `in_valid` high → entry replaced in one edge with no bubble.
- Flush: entry held plus new op presented with `flush`=1 → next cycle `out_valid`=0 and the new op is not captured.
- Reset: drop `rst_n` while FULL → all outputs 0 immediately; 10 back-to-back ops with `out_ready` high → 10 results in order, one per cycle.
